// File: rtl/cic_cfg_pkg.sv
// Shared definitions for the CIC configuration path: config word width,
// channel limit common to the CIC stages, and the config master FSM states.
package cic_cfg_pkg;

    localparam int CIC_CONFIG_DATA_WIDTH = 16;
    localparam int CIC_MAX_CHANNELS      = 16;

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_ASSERT,
        CFG_WAIT_DONE,
        CFG_WAIT_REL,
        CFG_FINISH
    } cfgState_t;

endpackage

// File: rtl/cic_cfg_timeout.sv
// Clearable saturating down-counter; Expired is high once CYCLES enabled
// edges have elapsed since the last Clear.
module cic_cfg_timeout #(
    parameter int CYCLES = 15
) (
    input  logic CLK,
    input  logic nRST,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);

    localparam int            CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    // Loaded with CYCLES-1 so the CYCLES-th enabled edge is the one that sees zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (Clear) begin
            count <= LOAD;
        end else if (Enable && count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign Expired = (count == '0);

endmodule

// File: rtl/cic_cfg_master.sv
// Configuration initiator for the CIC chain: runs the isConfig / ACK / Done
// handshake against one target or all targets in turn, with per-target timeout.
module cic_cfg_master
    import cic_cfg_pkg::*;
#(
    parameter int CFG_DATA_WIDTH = CIC_CONFIG_DATA_WIDTH,
    parameter int NUM_TARGETS    = 4,
    parameter int TGT_IDX_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      Cfg_Req,
    input  logic [CFG_DATA_WIDTH-1:0] Cfg_Data,
    input  logic [TGT_IDX_WIDTH-1:0]  Cfg_Target,
    input  logic                      Cfg_Broadcast,
    output logic                      Cfg_Busy,
    output logic                      Cfg_Done,
    output logic                      Cfg_Err,
    output logic [NUM_TARGETS-1:0]    Cfg_Err_Mask,
    output logic [NUM_TARGETS-1:0]    isConfig,
    output logic [CFG_DATA_WIDTH-1:0] Data_Config_Out,
    input  logic [NUM_TARGETS-1:0]    isConfigACK,
    input  logic [NUM_TARGETS-1:0]    isConfigDone
);

    cfgState_t                state;
    logic [TGT_IDX_WIDTH-1:0] tgt;
    logic                     bcast;

    logic [NUM_TARGETS-1:0] tgtSel;
    logic [NUM_TARGETS-1:0] failBit;
    logic [NUM_TARGETS-1:0] maskNext;
    logic doneSel, ackSel, released;
    logic reqValid, reqInRange, lastTgt;
    logic tmrClear, tmrEnable, tmrExpired;
    logic failNow, stepNow;

    // Only the selected target's handshake lines are ever looked at.
    assign tgtSel   = NUM_TARGETS'(1) << tgt;
    assign doneSel  = |(isConfigDone & tgtSel);
    assign ackSel   = |(isConfigACK & tgtSel);
    assign released = !ackSel && !doneSel;

    // A request coinciding with the completion pulse belongs to the old transaction.
    assign reqValid   = Cfg_Req && (state == CFG_IDLE) && !Cfg_Done;
    assign reqInRange = 32'(Cfg_Target) < NUM_TARGETS;
    assign lastTgt    = 32'(tgt) >= NUM_TARGETS - 1;

    assign tmrClear  = (state == CFG_ASSERT) || (state == CFG_WAIT_DONE && doneSel);
    assign tmrEnable = (state == CFG_WAIT_DONE) || (state == CFG_WAIT_REL);

    // Leaving a wait state (success or timeout) is the "next target" decision point.
    assign failNow  = tmrExpired && ((state == CFG_WAIT_DONE && !doneSel) ||
                                     (state == CFG_WAIT_REL  && !released));
    assign stepNow  = failNow || (state == CFG_WAIT_REL && released);
    assign failBit  = failNow ? tgtSel : '0;
    assign maskNext = Cfg_Err_Mask | failBit;

    cic_cfg_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) uTimeout (
        .CLK     (CLK),
        .nRST    (nRST),
        .Clear   (tmrClear),
        .Enable  (tmrEnable),
        .Expired (tmrExpired)
    );

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state           <= CFG_IDLE;
            tgt             <= '0;
            bcast           <= 1'b0;
            Cfg_Busy        <= 1'b0;
            Cfg_Done        <= 1'b0;
            Cfg_Err         <= 1'b0;
            Cfg_Err_Mask    <= '0;
            isConfig        <= '0;
            Data_Config_Out <= '0;
        end else begin
            Cfg_Done <= 1'b0;
            Cfg_Err  <= 1'b0;

            case (state)
                CFG_IDLE: begin
                    if (reqValid) begin
                        Cfg_Busy     <= 1'b1;
                        Cfg_Err_Mask <= '0;
                        bcast        <= Cfg_Broadcast;
                        if (Cfg_Broadcast) begin
                            tgt             <= '0;
                            isConfig        <= NUM_TARGETS'(1);
                            Data_Config_Out <= Cfg_Data;
                            state           <= CFG_ASSERT;
                        end else if (reqInRange) begin
                            tgt             <= Cfg_Target;
                            isConfig        <= NUM_TARGETS'(1) << Cfg_Target;
                            Data_Config_Out <= Cfg_Data;
                            state           <= CFG_ASSERT;
                        end else begin
                            tgt   <= Cfg_Target;
                            state <= CFG_FINISH;
                        end
                    end
                end
                CFG_ASSERT: begin
                    isConfig <= '0;
                    state    <= CFG_WAIT_DONE;
                end
                CFG_WAIT_DONE: begin
                    if (doneSel) state <= CFG_WAIT_REL;
                end
                CFG_WAIT_REL: begin
                end
                CFG_FINISH: begin
                    Cfg_Done <= 1'b1;
                    Cfg_Err  <= 1'b1;
                    Cfg_Busy <= 1'b0;
                    state    <= CFG_IDLE;
                end
                default: state <= CFG_IDLE;
            endcase

            if (stepNow) begin
                Cfg_Err_Mask <= maskNext;
                if (bcast && !lastTgt) begin
                    tgt      <= tgt + TGT_IDX_WIDTH'(1);
                    isConfig <= tgtSel << 1;
                    state    <= CFG_ASSERT;
                end else begin
                    Cfg_Done <= 1'b1;
                    Cfg_Err  <= |maskNext;
                    Cfg_Busy <= 1'b0;
                    state    <= CFG_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_cic_cfg_master.sv
// Randomized bench for cic_cfg_master: behavioural CIC stage slaves plus a
// transaction-level model predicting strobe timing, completion edge and error mask.
module tb_cic_cfg_master;

    localparam int NT = 4, DW = 16, TW = 4, TO = 15;
    localparam int M_OK = 0, M_DEAD = 1, M_STUCK = 2, M_NOISE = 3;
    localparam int BUDGET = 400;

    logic          CLK = 1'b0, nRST = 1'b0;
    logic          Cfg_Req = 1'b0, Cfg_Broadcast = 1'b0;
    logic [DW-1:0] Cfg_Data = '0;
    logic [TW-1:0] Cfg_Target = '0;
    logic          Cfg_Busy, Cfg_Done, Cfg_Err;
    logic [NT-1:0] Cfg_Err_Mask, isConfig;
    logic [DW-1:0] Data_Config_Out;
    logic [NT-1:0] isConfigACK = '0, isConfigDone = '0;

    int nChecks = 0, nPass = 0;

    cic_cfg_master #(
        .CFG_DATA_WIDTH (DW),
        .NUM_TARGETS    (NT),
        .TGT_IDX_WIDTH  (TW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK             (CLK),
        .nRST            (nRST),
        .Cfg_Req         (Cfg_Req),
        .Cfg_Data        (Cfg_Data),
        .Cfg_Target      (Cfg_Target),
        .Cfg_Broadcast   (Cfg_Broadcast),
        .Cfg_Busy        (Cfg_Busy),
        .Cfg_Done        (Cfg_Done),
        .Cfg_Err         (Cfg_Err),
        .Cfg_Err_Mask    (Cfg_Err_Mask),
        .isConfig        (isConfig),
        .Data_Config_Out (Data_Config_Out),
        .isConfigACK     (isConfigACK),
        .isConfigDone    (isConfigDone)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Slave state: behaviour mode, Done delay in cycles after ACK, phase, config register.
    int            sMode[NT], sDelay[NT], sCnt[NT];
    logic [DW-1:0] sReg[NT];
    logic [NT-1:0] lastIsCfg = '0, prevObs = '0;
    logic [DW-1:0] lastData = '0;
    int            gotTgt[$], gotEdge[$];
    int            badStrobe, busyDrop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One clock; slaves react to what they saw during the cycle just ended.
    task automatic step();
        @(posedge CLK);
        #1;
        for (int i = 0; i < NT; i++) begin
            case (sMode[i])
                M_NOISE: begin
                    isConfigACK[i]  = 1'($urandom_range(0, 1));
                    isConfigDone[i] = 1'($urandom_range(0, 1));
                end
                M_DEAD: begin
                end
                default: begin
                    if (lastIsCfg[i]) begin
                        sCnt[i] = 1;
                        isConfigACK[i] = 1'b1;
                        sReg[i] = lastData;
                    end else if (sCnt[i] > 0) begin
                        sCnt[i]++;
                        if (sCnt[i] == 1 + sDelay[i]) isConfigDone[i] = 1'b1;
                        if (sCnt[i] == 2 + sDelay[i]) begin
                            isConfigDone[i] = 1'b0;
                            if (sMode[i] != M_STUCK) isConfigACK[i] = 1'b0;
                            sCnt[i] = 0;
                        end
                    end
                end
            endcase
        end
        lastIsCfg = isConfig;
        lastData  = Data_Config_Out;
    endtask

    task automatic resetSlaves();
        isConfigACK  = '0;
        isConfigDone = '0;
        for (int i = 0; i < NT; i++) sCnt[i] = 0;
    endtask

    task automatic setAll(input int mode, input int delay);
        for (int i = 0; i < NT; i++) begin
            sMode[i]  = mode;
            sDelay[i] = delay;
        end
    endtask

    task automatic observe(input int k);
        if (isConfig != '0) begin
            if ($countones(isConfig) != 1) badStrobe++;
            if ((isConfig & prevObs) != '0) badStrobe++;
            for (int i = 0; i < NT; i++)
                if (isConfig[i]) begin
                    gotTgt.push_back(i);
                    gotEdge.push_back(k);
                end
        end
        prevObs = isConfig;
    endtask

    task automatic runTxn(input logic [DW-1:0] data, input int target, input bit bcast,
                          input bit busyReq, input bit reqOnDone);
        int            expTgt[$], expEdge[$];
        logic [NT-1:0] expMask;
        logic [DW-1:0] expReg;
        int            s, dur, expDone, k;
        bit            invalid, expErr, served, fail;

        // Reference: each served target costs a fixed number of cycles set by its behaviour.
        expMask = '0;
        s = 0;
        invalid = !bcast && target >= NT;
        for (int t = 0; t < NT; t++) begin
            if (bcast || t == target) begin
                if (sMode[t] != M_DEAD && sDelay[t] <= TO - 1) begin
                    if (sMode[t] == M_STUCK) begin dur = 2 + sDelay[t] + TO; fail = 1'b1; end
                    else                     begin dur = 3 + sDelay[t];      fail = 1'b0; end
                end else begin
                    dur = 1 + TO;
                    fail = 1'b1;
                end
                expTgt.push_back(t);
                expEdge.push_back(s);
                s += dur;
                if (fail) expMask[t] = 1'b1;
            end
        end
        expDone = invalid ? 1 : s;
        expErr  = invalid || (expMask != '0);

        resetSlaves();
        for (int i = 0; i < NT; i++) sReg[i] = ~data;
        gotTgt.delete();
        gotEdge.delete();
        badStrobe = 0;
        busyDrop  = 0;

        Cfg_Data = data;
        Cfg_Target = TW'(target);
        Cfg_Broadcast = bcast;
        Cfg_Req = 1'b1;
        step();
        Cfg_Req = 1'b0;
        k = 0;
        check("busy_set", 32'(Cfg_Busy), 32'd1);
        prevObs = '0;
        observe(0);
        while (!Cfg_Done && k < BUDGET) begin
            if (busyReq && k == 2) begin
                Cfg_Req       = 1'b1;
                Cfg_Target    = TW'($urandom_range(0, NT - 1));
                Cfg_Data      = DW'($urandom);
                Cfg_Broadcast = 1'($urandom_range(0, 1));
            end
            step();
            Cfg_Req = 1'b0;
            k++;
            if (!Cfg_Done && !Cfg_Busy) busyDrop++;
            observe(k);
        end

        check("done_edge", 32'(k), 32'(expDone));
        check("err", 32'(Cfg_Err), 32'(expErr));
        check("err_mask", 32'(Cfg_Err_Mask), 32'(expMask));
        check("busy_clear", 32'(Cfg_Busy), 32'd0);
        check("busy_during", 32'(busyDrop), 32'd0);
        check("strobe_shape", 32'(badStrobe), 32'd0);
        check("pulse_count", 32'(gotTgt.size()), 32'(expTgt.size()));
        for (int i = 0; i < expTgt.size() && i < gotTgt.size(); i++) begin
            check("pulse_target", 32'(gotTgt[i]), 32'(expTgt[i]));
            check("pulse_edge", 32'(gotEdge[i]), 32'(expEdge[i]));
        end
        if (!invalid) check("data_out", 32'(Data_Config_Out), 32'(data));
        for (int t = 0; t < NT; t++) begin
            served = bcast || t == target;
            expReg = (served && sMode[t] != M_DEAD) ? data : ~data;
            check("slave_reg", 32'(sReg[t]), 32'(expReg));
        end

        if (reqOnDone) begin
            Cfg_Req = 1'b1;
            Cfg_Target = '0;
            Cfg_Broadcast = 1'b0;
            Cfg_Data = ~data;
        end
        step();
        Cfg_Req = 1'b0;
        check("done_pulse", 32'(Cfg_Done), 32'd0);
        check("err_pulse", 32'(Cfg_Err), 32'd0);
        check("mask_hold", 32'(Cfg_Err_Mask), 32'(expMask));
        check("idle_strobe", 32'(isConfig), 32'd0);
        check("idle_busy", 32'(Cfg_Busy), 32'd0);
        if (!invalid) check("data_hold", 32'(Data_Config_Out), 32'(data));
    endtask

    task automatic randomSlaves(input int target, input bit bcast);
        for (int i = 0; i < NT; i++) begin
            int r;
            r = $urandom_range(0, 9);
            sMode[i]  = (r < 6) ? M_OK : (r < 8) ? M_DEAD : M_STUCK;
            sDelay[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 17) : $urandom_range(2, 5);
            if (!bcast && i != target) sMode[i] = $urandom_range(0, 1) ? M_NOISE : M_OK;
        end
    endtask

    initial begin
        bit doneSeen;
        setAll(M_OK, 2);
        resetSlaves();

        repeat (3) @(posedge CLK);
        #1;
        check("reset_busy", 32'(Cfg_Busy), 32'd0);
        check("reset_done", 32'(Cfg_Done), 32'd0);
        check("reset_err", 32'(Cfg_Err), 32'd0);
        check("reset_mask", 32'(Cfg_Err_Mask), 32'd0);
        check("reset_strobe", 32'(isConfig), 32'd0);
        check("reset_data", 32'(Data_Config_Out), 32'd0);
        nRST = 1'b1;
        step();

        setAll(M_OK, 2);
        runTxn(16'h0005, 0, 1'b0, 1'b0, 1'b0);
        runTxn(16'h0003, 0, 1'b1, 1'b0, 1'b0);
        sMode[2] = M_DEAD;
        runTxn(16'h0042, 2, 1'b0, 1'b0, 1'b0);
        setAll(M_OK, 2);
        sMode[1] = M_DEAD;
        runTxn(16'h0077, 0, 1'b1, 1'b0, 1'b0);
        setAll(M_OK, 2);
        runTxn(16'h0099, 7, 1'b0, 1'b0, 1'b1);
        runTxn(16'hBEEF, 3, 1'b0, 1'b1, 1'b1);
        sDelay[1] = TO - 1;
        runTxn(16'h0101, 1, 1'b0, 1'b0, 1'b0);
        sDelay[1] = TO;
        runTxn(16'h0202, 1, 1'b0, 1'b0, 1'b0);

        // Reset while the master waits on an unresponsive target.
        setAll(M_DEAD, 2);
        resetSlaves();
        Cfg_Data = 16'hA5A5;
        Cfg_Target = TW'(1);
        Cfg_Broadcast = 1'b0;
        Cfg_Req = 1'b1;
        step();
        Cfg_Req = 1'b0;
        repeat (4) step();
        nRST = 1'b0;
        #1;
        check("rst_mid_busy", 32'(Cfg_Busy), 32'd0);
        check("rst_mid_strobe", 32'(isConfig), 32'd0);
        check("rst_mid_data", 32'(Data_Config_Out), 32'd0);
        check("rst_mid_mask", 32'(Cfg_Err_Mask), 32'd0);
        check("rst_mid_err", 32'(Cfg_Err), 32'd0);
        doneSeen = 1'b0;
        repeat (3) begin
            step();
            if (Cfg_Done) doneSeen = 1'b1;
        end
        check("rst_mid_no_done", 32'(doneSeen), 32'd0);
        nRST = 1'b1;
        setAll(M_OK, 2);
        resetSlaves();
        step();
        runTxn(16'h1234, 1, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int tgtPick;
            bit bc;
            bc = ($urandom_range(0, 3) == 0);
            tgtPick = ($urandom_range(0, 4) == 0) ? $urandom_range(NT, 15) : $urandom_range(0, NT - 1);
            randomSlaves(tgtPick, bc);
            runTxn(DW'($urandom), tgtPick, bc,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
